// File: rtl/qsys_device_fifo.sv
// Byte FIFO behind a four-register memory-mapped slave, with a streaming
// drain port. Reads take two cycles; writes complete in one cycle.
module qsys_device_fifo #(
  parameter int address_size = 8,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                    csi_MCLK_clk,
  input  logic                    rsi_MRST_reset_n,
  input  logic [address_size-1:0] device_address,
  input  logic [7:0]              device_writedata,
  output logic [7:0]              device_readdata,
  input  logic                    device_write,
  input  logic                    device_read,
  output logic                    device_waitrequest,
  output logic [7:0]              st_data,
  output logic                    st_valid,
  input  logic                    st_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [address_size-1:0] ADDR_DATA   = address_size'(0);
  localparam logic [address_size-1:0] ADDR_STATUS = address_size'(1);
  localparam logic [address_size-1:0] ADDR_COUNT  = address_size'(2);
  localparam logic [address_size-1:0] ADDR_CTRL   = address_size'(3);
  localparam logic [CNT_W-1:0]        CNT_FULL    = CNT_W'(FIFO_DEPTH);

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             underflow;
  logic             stream_en;
  logic             rd_ack;

  logic       empty;
  logic       full;
  logic       rd_first;
  logic       sel_data;
  logic       sel_status;
  logic       sel_ctrl;
  logic       dev_pop;
  logic       st_pop;
  logic       pop;
  logic       push_req;
  logic       push;
  logic       flush;
  logic [7:0] head;
  logic [7:0] rd_mux;

  assign empty    = (count == '0);
  assign full     = (count == CNT_FULL);
  // Stale storage never leaks out: the head reads as zero while empty.
  assign head     = empty ? 8'h00 : mem[rd_ptr];

  assign sel_data   = (device_address == ADDR_DATA);
  assign sel_status = (device_address == ADDR_STATUS);
  assign sel_ctrl   = (device_address == ADDR_CTRL);

  // First cycle of a read: the edge that captures readdata and pops DATA.
  assign rd_first           = device_read & ~rd_ack;
  assign device_waitrequest = rd_first;

  assign st_valid = stream_en & ~empty;
  assign st_data  = head;

  assign dev_pop  = rd_first & sel_data & ~stream_en & ~empty;
  assign st_pop   = st_valid & st_ready;
  assign pop      = dev_pop | st_pop;
  assign flush    = device_write & sel_ctrl & device_writedata[1];
  assign push_req = device_write & sel_data;
  // A simultaneous pop frees a slot, so a full FIFO still accepts the push.
  assign push     = push_req & (~full | pop) & ~flush;

  // NOTE: every path assigns a default first so no latch is inferred.
  always_comb begin
    rd_mux = 8'h00;
    case (device_address)
      ADDR_DATA:   rd_mux = head;
      ADDR_STATUS: rd_mux = {3'b000, stream_en, underflow, overflow, full, empty};
      ADDR_COUNT:  rd_mux = 8'(count);
      ADDR_CTRL:   rd_mux = {7'b0, stream_en};
      default:     rd_mux = 8'h00;
    endcase
  end

  // NOTE: storage has no reset; it is only observable through head, which is
  // masked while empty, so resetting it would add logic with no effect.
  always_ff @(posedge csi_MCLK_clk) begin
    if (push) mem[wr_ptr] <= device_writedata;
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      overflow        <= 1'b0;
      underflow       <= 1'b0;
      stream_en       <= 1'b0;
      rd_ack          <= 1'b0;
      device_readdata <= 8'h00;
    end else begin
      rd_ack <= rd_first;
      if (rd_first) device_readdata <= rd_mux;

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end

      if (push_req & full & ~pop & ~flush)
        overflow <= 1'b1;
      else if (device_write & sel_status & device_writedata[2])
        overflow <= 1'b0;

      if (rd_first & sel_data & ~stream_en & empty)
        underflow <= 1'b1;
      else if (device_write & sel_status & device_writedata[3])
        underflow <= 1'b0;

      if (device_write & sel_ctrl) stream_en <= device_writedata[0];
    end
  end

endmodule
